// File: rtl/tow_input_conditioner.sv
// Tug-of-war player input front end: synchronizes and debounces both buttons.
// Turns each accepted press into one gated pulse; simultaneous presses cancel.
module tow_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic l_press,
  output logic r_press,
  output logic l_held,
  output logic r_held,
  output logic tie_drop
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the left channel, index 1 the right channel.
  logic [1:0]             key_n;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [CNT_W-1:0]       cnt_d  [2];
  logic [1:0]             s;
  logic [1:0]             held_q, held_d;
  logic [1:0]             rise;
  logic                   l_press_q, l_press_d;
  logic                   r_press_q, r_press_d;
  logic                   tie_q, tie_d;

  assign key_n = {key_r_n, key_l_n};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], key_n[i]};
      s[i]      = ~sync_q[i][SYNC_STAGES-1];
      held_d[i] = held_q[i];
      cnt_d[i]  = '0;
      rise[i]   = 1'b0;
      // The counter restarts on any agreeing sample, so short glitches never land.
      if (s[i] != held_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          held_d[i] = ~held_q[i];
          rise[i]   = ~held_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    l_press_d = rise[0] & ~rise[1] & enable;
    r_press_d = rise[1] & ~rise[0] & enable;
    tie_d     = rise[0] &  rise[1] & enable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      held_q    <= '0;
      l_press_q <= 1'b0;
      r_press_q <= 1'b0;
      tie_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      held_q    <= held_d;
      l_press_q <= l_press_d;
      r_press_q <= r_press_d;
      tie_q     <= tie_d;
    end
  end

  assign l_press  = l_press_q;
  assign r_press  = r_press_q;
  assign l_held   = held_q[0];
  assign r_held   = held_q[1];
  assign tie_drop = tie_q;

endmodule

// File: tb/tb_tow_input_conditioner.sv
// Self-checking bench for tow_input_conditioner: segment table plus hand-written
// sequences, with expected outputs queued per driven cycle and checked after the edge.
module tb_tow_input_conditioner;

  logic clk = 1'b0;
  logic reset, key_l_n, key_r_n, enable;
  logic l_press, r_press, l_held, r_held, tie_drop;

  always #5 clk = ~clk;

  tow_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .enable  (enable),
    .l_press (l_press),
    .r_press (r_press),
    .l_held  (l_held),
    .r_held  (r_held),
    .tie_drop(tie_drop)
  );

  // Expected vector bit order: {l_press, r_press, l_held, r_held, tie_drop}
  localparam logic [4:0] Z   = 5'b00000;
  localparam logic [4:0] LH  = 5'b00100;
  localparam logic [4:0] RH  = 5'b00010;
  localparam logic [4:0] LP  = 5'b10100;
  localparam logic [4:0] RP  = 5'b01010;
  localparam logic [4:0] BH  = 5'b00110;
  localparam logic [4:0] TIE = 5'b00111;
  localparam logic [4:0] LPR = 5'b10110;
  localparam logic [4:0] RPL = 5'b01110;

  typedef struct {
    logic       rst;
    logic       kl;
    logic       kr;
    logic       en;
    int         n;
    logic [4:0] exp;
    string      name;
  } seg_t;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } sb_t;

  seg_t segs[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic kl, input logic kr, input logic en,
                     input int n, input logic [4:0] exp, input string name);
    seg_t s;
    s.rst = rst; s.kl = kl; s.kr = kr; s.en = en; s.n = n; s.exp = exp; s.name = name;
    segs.push_back(s);
  endtask

  task automatic step(input logic rst, input logic kl, input logic kr, input logic en,
                      input logic [4:0] exp, input string name);
    sb_t e;
    logic [4:0] act;
    @(negedge clk);
    reset = rst; key_l_n = kl; key_r_n = kr; enable = en;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    act = {l_press, r_press, l_held, r_held, tie_drop};
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s @%0t: got {lp,rp,lh,rh,tie}=%b want %b", e.name, $time, act, e.exp);
      end
    end
  endtask

  task automatic run(input logic rst, input logic kl, input logic kr, input logic en,
                     input int n, input logic [4:0] exp, input string name);
    for (int c = 0; c < n; c++) step(rst, kl, kr, en, exp, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_l_n = 1'b1; key_r_n = 1'b1; enable = 1'b1;

    add(1, 1, 1, 1,  3, Z,   "reset");
    add(0, 1, 1, 1,  4, Z,   "idle");
    // Single left press held 20 cycles, released 10, pressed again.
    add(0, 0, 1, 1,  5, Z,   "l_press_latency");
    add(0, 0, 1, 1,  1, LP,  "l_press_pulse");
    add(0, 0, 1, 1, 14, LH,  "l_hold_no_repeat");
    add(0, 1, 1, 1,  5, LH,  "l_release_latency");
    add(0, 1, 1, 1,  5, Z,   "l_released");
    add(0, 0, 1, 1,  5, Z,   "l_repress_latency");
    add(0, 0, 1, 1,  1, LP,  "l_repress_pulse");
    add(0, 0, 1, 1,  4, LH,  "l_repress_hold");
    add(0, 1, 1, 1,  5, LH,  "l_release2");
    add(0, 1, 1, 1,  5, Z,   "l_released2");
    // Right bounce: low 2, high 1, then low stays.
    add(0, 1, 0, 1,  2, Z,   "r_bounce_low");
    add(0, 1, 1, 1,  1, Z,   "r_bounce_high");
    add(0, 1, 0, 1,  5, Z,   "r_stable_latency");
    add(0, 1, 0, 1,  1, RP,  "r_press_pulse");
    add(0, 1, 0, 1,  6, RH,  "r_hold");
    add(0, 1, 1, 1,  5, RH,  "r_release_latency");
    add(0, 1, 1, 1,  5, Z,   "r_released");
    // Simultaneous press cancels.
    add(0, 0, 0, 1,  5, Z,   "tie_latency");
    add(0, 0, 0, 1,  1, TIE, "tie_pulse");
    add(0, 0, 0, 1,  4, BH,  "tie_hold");
    add(0, 1, 1, 1,  5, BH,  "tie_release_latency");
    add(0, 1, 1, 1,  5, Z,   "tie_released");
    // Press while disabled, then enable while still held.
    add(0, 0, 1, 0,  5, Z,   "dis_latency");
    add(0, 0, 1, 0,  1, LH,  "dis_no_pulse");
    add(0, 0, 1, 0,  4, LH,  "dis_hold");
    add(0, 0, 1, 1,  6, LH,  "en_rise_no_pulse");
    add(0, 1, 1, 1,  5, LH,  "dis_release_latency");
    add(0, 1, 1, 1,  5, Z,   "dis_released");

    foreach (segs[i])
      run(segs[i].rst, segs[i].kl, segs[i].kr, segs[i].en, segs[i].n, segs[i].exp, segs[i].name);

    // Reset asserted mid-press while the key stays held.
    run(0, 0, 1, 1, 5, Z,  "pre_rst_latency");
    run(0, 0, 1, 1, 1, LP, "pre_rst_pulse");
    run(0, 0, 1, 1, 2, LH, "pre_rst_hold");
    run(1, 0, 1, 1, 3, Z,  "mid_reset");
    run(0, 0, 1, 1, 5, Z,  "post_rst_latency");
    run(0, 0, 1, 1, 1, LP, "post_rst_pulse");
    run(0, 0, 1, 1, 4, LH, "post_rst_hold");
    run(0, 1, 1, 1, 5, LH, "post_rst_release");
    run(0, 1, 1, 1, 5, Z,  "post_rst_released");

    // Staggered presses: right first, left two cycles later, both pulse separately.
    run(0, 1, 0, 1, 2, Z,   "stag_r_only");
    run(0, 0, 0, 1, 3, Z,   "stag_both_low");
    run(0, 0, 0, 1, 1, RP,  "stag_r_pulse");
    run(0, 0, 0, 1, 1, RH,  "stag_gap");
    run(0, 0, 0, 1, 1, LPR, "stag_l_pulse");
    run(0, 0, 0, 1, 3, BH,  "stag_both_hold");
    run(0, 1, 1, 1, 5, BH,  "stag_release");
    run(0, 1, 1, 1, 3, Z,   "stag_released");

    // Left held, right pressed later: right still pulses alone.
    run(0, 0, 1, 1, 5, Z,   "lr_l_latency");
    run(0, 0, 1, 1, 1, LP,  "lr_l_pulse");
    run(0, 0, 0, 1, 5, LH,  "lr_r_latency");
    run(0, 0, 0, 1, 1, RPL, "lr_r_pulse");
    run(0, 0, 0, 1, 2, BH,  "lr_both_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
